// File: rtl/ip_dispatch_pkg.sv
// Shared constants for the image-processor dispatcher: default parameters,
// frame FSM state encoding and an index-width helper.
package ip_dispatch_pkg;

  localparam int unsigned IP_AMT_DEF       = 4;
  localparam int unsigned AXIS_TDATA_W_DEF = 256;
  localparam int unsigned AXIS_TID_W_DEF   = 2;
  localparam int unsigned AXIS_TDEST_W_DEF = 4;
  localparam int unsigned SW_W_DEF         = 11;

  typedef logic [1:0] fsm_state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUTE = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;

  // Index width for n items, never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ip_rr_arb.sv
// Round-robin arbiter: one-hot grant, search starts at the lane after the
// last granted one; the pointer moves only when advance accepts a grant.
module ip_rr_arb #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] gidx;
  logic          found;
  int unsigned   idx;

  always_comb begin
    grant = '0;
    gidx  = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = (32'(ptr_q) + i) % N;
      if (!found && req[PW'(idx)]) begin
        grant[PW'(idx)] = 1'b1;
        gidx            = PW'(idx);
        found           = 1'b1;
      end
    end
  end

  // Reset pointer at the last lane so lane 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= PW'(N - 1);
    end else if (advance && found) begin
      ptr_q <= gidx;
    end
  end

endmodule

// File: rtl/ip_dispatch.sv
// Routes AXI-Stream frames to one of IP_AMT lanes by tdest and merges per-lane
// result pulses into one stream. Define IP_DISPATCH_OVF_EN for ovf_o/ovf_clr_i.
module ip_dispatch
  import ip_dispatch_pkg::*;
#(
  parameter int unsigned IP_AMT       = IP_AMT_DEF,
  parameter int unsigned IP_ADDR_W    = idx_w(IP_AMT),
  parameter int unsigned AXIS_TDATA_W = AXIS_TDATA_W_DEF,
  parameter int unsigned AXIS_TID_W   = AXIS_TID_W_DEF,
  parameter int unsigned AXIS_TDEST_W = AXIS_TDEST_W_DEF,
  parameter int unsigned SW_W         = SW_W_DEF
) (
  input  logic                           s_aclk,
  input  logic                           s_aresetn,
  input  logic [AXIS_TID_W-1:0]          s_tid_i,
  input  logic [AXIS_TDEST_W-1:0]        s_tdest_i,
  input  logic [AXIS_TDATA_W-1:0]        s_tdata_i,
  input  logic [AXIS_TDATA_W/8-1:0]      s_tkeep_i,
  input  logic [AXIS_TDATA_W/8-1:0]      s_tstrb_i,
  input  logic                           s_tlast_i,
  input  logic                           s_tvalid_i,
  output logic                           s_tready_o,
  output logic [IP_AMT*AXIS_TDATA_W-1:0] m_tdata_o,
  output logic [IP_AMT-1:0]              m_tlast_o,
  output logic [IP_AMT-1:0]              m_tvalid_o,
  input  logic [IP_AMT-1:0]              m_tready_i,
  input  logic [IP_AMT-1:0]              res_valid_i,
  input  logic [IP_AMT-1:0]              res_person_i,
  input  logic [IP_AMT*SW_W-1:0]         res_swid_i,
`ifdef IP_DISPATCH_OVF_EN
  output logic [IP_AMT-1:0]              ovf_o,
  input  logic                           ovf_clr_i,
`endif
  output logic                           r_valid_o,
  output logic                           r_person_o,
  output logic [SW_W-1:0]                r_swid_o,
  output logic [IP_ADDR_W-1:0]           r_lane_o,
  input  logic                           r_ready_i
);

  fsm_state_t           state_q, state_d;
  logic [IP_ADDR_W-1:0] sel_q, sel_d;
  logic                 dest_ok;
  logic                 unused_sideband;

  assign unused_sideband = ^{s_tid_i, s_tkeep_i, s_tstrb_i};
  assign dest_ok         = 32'(s_tdest_i) < IP_AMT;

  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  // Frame FSM: lane is latched at frame start and held until tlast handshakes.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    s_tready_o = 1'b0;
    m_tvalid_o = '0;
    m_tlast_o  = '0;
    m_tdata_o  = '0;
    case (state_q)
      ST_IDLE: begin
        if (s_tvalid_i) begin
          sel_d   = IP_ADDR_W'(s_tdest_i);
          state_d = dest_ok ? ST_ROUTE : ST_DROP;
        end
      end
      ST_ROUTE: begin
        s_tready_o        = m_tready_i[sel_q];
        m_tvalid_o[sel_q] = s_tvalid_i;
        m_tlast_o[sel_q]  = s_tlast_i;
        m_tdata_o[32'(sel_q)*AXIS_TDATA_W +: AXIS_TDATA_W] = s_tdata_i;
        if (s_tvalid_i && m_tready_i[sel_q] && s_tlast_i) begin
          state_d = ST_IDLE;
        end
      end
      ST_DROP: begin
        s_tready_o = 1'b1;
        if (s_tvalid_i && s_tlast_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  logic [IP_AMT-1:0]           hold_vld;
  logic [IP_AMT-1:0]           hold_person;
  logic [IP_AMT-1:0][SW_W-1:0] hold_swid;
  logic [IP_AMT-1:0]           grant;
  logic [IP_AMT-1:0]           drain;
  logic                        out_load;
  logic [IP_ADDR_W-1:0]        g_idx;
  logic                        g_person;
  logic [SW_W-1:0]             g_swid;

  assign out_load = !r_valid_o || r_ready_i;
  assign drain    = grant & {IP_AMT{out_load}};

  // Per-lane one-entry holding registers; a draining entry may be refilled.
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      hold_vld    <= '0;
      hold_person <= '0;
      hold_swid   <= '0;
    end else begin
      for (int unsigned k = 0; k < IP_AMT; k++) begin
        if (res_valid_i[k] && (!hold_vld[k] || drain[k])) begin
          hold_vld[k]    <= 1'b1;
          hold_person[k] <= res_person_i[k];
          hold_swid[k]   <= res_swid_i[k*SW_W +: SW_W];
        end else if (drain[k]) begin
          hold_vld[k] <= 1'b0;
        end
      end
    end
  end

  ip_rr_arb #(
    .N (IP_AMT)
  ) u_arb (
    .clk     (s_aclk),
    .rst_n   (s_aresetn),
    .req     (hold_vld),
    .advance (out_load),
    .grant   (grant)
  );

  always_comb begin
    g_idx    = '0;
    g_person = 1'b0;
    g_swid   = '0;
    for (int unsigned k = 0; k < IP_AMT; k++) begin
      if (grant[k]) begin
        g_idx    = IP_ADDR_W'(k);
        g_person = hold_person[k];
        g_swid   = hold_swid[k];
      end
    end
  end

  // Merged result register, stalls while the consumer is not ready.
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      r_valid_o  <= 1'b0;
      r_person_o <= 1'b0;
      r_swid_o   <= '0;
      r_lane_o   <= '0;
    end else if (out_load) begin
      r_valid_o <= |hold_vld;
      if (|hold_vld) begin
        r_person_o <= g_person;
        r_swid_o   <= g_swid;
        r_lane_o   <= g_idx;
      end
    end
  end

`ifdef IP_DISPATCH_OVF_EN
  // Sticky drop flags; a new drop wins over a clear in the same cycle.
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      ovf_o <= '0;
    end else begin
      ovf_o <= (ovf_o & ~{IP_AMT{ovf_clr_i}}) | (res_valid_i & hold_vld & ~drain);
    end
  end
`endif

endmodule

// File: tb/tb_ip_dispatch.sv
// Bench for ip_dispatch: frame routing scenarios and randomized result traffic
// compared against a behavioural model. Honors IP_DISPATCH_OVF_EN.
module tb_ip_dispatch;

  localparam int N    = 4;
  localparam int AW   = 2;
  localparam int DW   = 256;
  localparam int TIDW = 2;
  localparam int TDW  = 4;
  localparam int SWW  = 11;
  localparam int RW   = 1 + AW + 1 + SWW;

  logic              clk;
  logic              s_aresetn;
  logic [TIDW-1:0]   s_tid_i;
  logic [TDW-1:0]    s_tdest_i;
  logic [DW-1:0]     s_tdata_i;
  logic [DW/8-1:0]   s_tkeep_i;
  logic [DW/8-1:0]   s_tstrb_i;
  logic              s_tlast_i;
  logic              s_tvalid_i;
  logic              s_tready_o;
  logic [N*DW-1:0]   m_tdata_o;
  logic [N-1:0]      m_tlast_o;
  logic [N-1:0]      m_tvalid_o;
  logic [N-1:0]      m_tready_i;
  logic [N-1:0]      res_valid_i;
  logic [N-1:0]      res_person_i;
  logic [N*SWW-1:0]  res_swid_i;
  logic              r_valid_o;
  logic              r_person_o;
  logic [SWW-1:0]    r_swid_o;
  logic [AW-1:0]     r_lane_o;
  logic              r_ready_i;
`ifdef IP_DISPATCH_OVF_EN
  logic [N-1:0]      ovf_o;
  logic              ovf_clr_i;
`endif

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model of the result path: pending slot per lane, output slot.
  bit             m_hv[N];
  bit             m_hp[N];
  logic [SWW-1:0] m_hs[N];
  bit             m_rv;
  int             m_rl;
  bit             m_rp;
  logic [SWW-1:0] m_rs;
  int             m_last;
  logic [N-1:0]   m_ovf;

  ip_dispatch #(
    .IP_AMT       (N),
    .IP_ADDR_W    (AW),
    .AXIS_TDATA_W (DW),
    .AXIS_TID_W   (TIDW),
    .AXIS_TDEST_W (TDW),
    .SW_W         (SWW)
  ) dut (
    .s_aclk       (clk),
    .s_aresetn    (s_aresetn),
    .s_tid_i      (s_tid_i),
    .s_tdest_i    (s_tdest_i),
    .s_tdata_i    (s_tdata_i),
    .s_tkeep_i    (s_tkeep_i),
    .s_tstrb_i    (s_tstrb_i),
    .s_tlast_i    (s_tlast_i),
    .s_tvalid_i   (s_tvalid_i),
    .s_tready_o   (s_tready_o),
    .m_tdata_o    (m_tdata_o),
    .m_tlast_o    (m_tlast_o),
    .m_tvalid_o   (m_tvalid_o),
    .m_tready_i   (m_tready_i),
    .res_valid_i  (res_valid_i),
    .res_person_i (res_person_i),
    .res_swid_i   (res_swid_i),
`ifdef IP_DISPATCH_OVF_EN
    .ovf_o        (ovf_o),
    .ovf_clr_i    (ovf_clr_i),
`endif
    .r_valid_o    (r_valid_o),
    .r_person_o   (r_person_o),
    .r_swid_o     (r_swid_o),
    .r_lane_o     (r_lane_o),
    .r_ready_i    (r_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [RW-1:0] exp_r();
    return m_rv ? {1'b1, AW'(m_rl), m_rp, m_rs} : RW'(0);
  endfunction

  function automatic logic [RW-1:0] got_r();
    return m_rv ? {r_valid_o, r_lane_o, r_person_o, r_swid_o} : {r_valid_o, (RW-1)'(0)};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_hv[k] = 0; m_hp[k] = 0; m_hs[k] = '0;
    end
    m_rv = 0; m_rl = 0; m_rp = 0; m_rs = '0; m_last = N - 1; m_ovf = '0;
  endtask

  // Drive one cycle of result-side inputs and advance the model across the edge.
  task automatic res_step(input logic [N-1:0] v, input logic [N-1:0] p,
                          input logic [N*SWW-1:0] s, input logic rdy, input logic clr);
    int g;
    int drained;
    logic [N-1:0] drops;
    res_valid_i = v; res_person_i = p; res_swid_i = s; r_ready_i = rdy;
`ifdef IP_DISPATCH_OVF_EN
    ovf_clr_i = clr;
`endif
    g = -1;
    for (int i = 1; i <= N; i++) begin
      int l;
      l = (m_last + i) % N;
      if (g < 0 && m_hv[l]) g = l;
    end
    drained = -1;
    if (!m_rv || rdy) begin
      if (g >= 0) begin
        m_rv = 1; m_rl = g; m_rp = m_hp[g]; m_rs = m_hs[g]; m_last = g; drained = g;
      end else begin
        m_rv = 0;
      end
    end
    drops = '0;
    for (int k = 0; k < N; k++) begin
      if (v[k]) begin
        if (!m_hv[k] || drained == k) begin
          m_hv[k] = 1; m_hp[k] = p[k]; m_hs[k] = s[k*SWW +: SWW];
        end else begin
          drops[k] = 1'b1;
        end
      end else if (drained == k) begin
        m_hv[k] = 0;
      end
    end
    if (clr) m_ovf = '0;
    m_ovf = m_ovf | drops;
    @(posedge clk);
    @(negedge clk);
  endtask

  // One frame through the stream path with beat-by-beat comparisons.
  task automatic run_frame(input int dest, input int nbeats, input bit scramble, input bit rand_rdy);
    bit           routed;
    logic [N-1:0] onehot;
    logic         exp_rdy;
    logic [N-1:0] exp_mv;
    int           b;
    int           cyc;
    routed = dest < N;
    onehot = routed ? N'(1) << dest : '0;
    @(negedge clk);
    s_tvalid_i = 1'b1; s_tdest_i = TDW'(dest); s_tlast_i = (nbeats == 1);
    s_tdata_i = rand_data(); m_tready_i = '1;
    #1;
    n_total++;
    if ({s_tready_o, m_tvalid_o} !== '0)
      $display("FAIL frame_start_gap: tready=%0b tvalid=%b want 0/0000", s_tready_o, m_tvalid_o);
    else n_pass++;
    b = 0; cyc = 0;
    while (b < nbeats && cyc < 200) begin
      @(negedge clk);
      cyc++;
      s_tvalid_i = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_tdata_i  = rand_data();
      s_tlast_i  = (b == nbeats - 1);
      if (scramble) s_tdest_i = TDW'($urandom);
      m_tready_i = rand_rdy ? N'($urandom) : '1;
      #1;
      exp_rdy = routed ? |(m_tready_i & onehot) : 1'b1;
      exp_mv  = s_tvalid_i ? onehot : '0;
      n_total++;
      if ({s_tready_o, m_tvalid_o} !== {exp_rdy, exp_mv})
        $display("FAIL frame_beat dest=%0d beat=%0d: tready=%0b tvalid=%b want %0b %b",
                 dest, b, s_tready_o, m_tvalid_o, exp_rdy, exp_mv);
      else n_pass++;
      if (routed && s_tvalid_i) begin
        n_total++;
        if (m_tdata_o[dest*DW +: DW] !== s_tdata_i || m_tlast_o !== (s_tlast_i ? onehot : '0))
          $display("FAIL frame_payload dest=%0d beat=%0d: tlast=%b want %b data_match=%0b",
                   dest, b, m_tlast_o, (s_tlast_i ? onehot : '0), m_tdata_o[dest*DW +: DW] === s_tdata_i);
        else n_pass++;
      end
      if (s_tvalid_i && exp_rdy) b++;
    end
    if (b < nbeats) begin
      n_total++;
      $display("FAIL frame_timeout dest=%0d: accepted %0d of %0d beats", dest, b, nbeats);
    end
    @(negedge clk);
    s_tvalid_i = 1'b0; s_tlast_i = 1'b0; m_tready_i = '1;
    #1;
    n_total++;
    if ({s_tready_o, m_tvalid_o} !== '0)
      $display("FAIL frame_back_to_idle dest=%0d: tready=%0b tvalid=%b want 0/0000", dest, s_tready_o, m_tvalid_o);
    else n_pass++;
  endtask

  task automatic test_reset();
    s_aresetn = 1'b0;
    s_tid_i = '0; s_tdest_i = '0; s_tdata_i = '0; s_tkeep_i = '1; s_tstrb_i = '1;
    s_tlast_i = 1'b0; s_tvalid_i = 1'b0; m_tready_i = '1;
    res_valid_i = '0; res_person_i = '0; res_swid_i = '0; r_ready_i = 1'b1;
`ifdef IP_DISPATCH_OVF_EN
    ovf_clr_i = 1'b0;
`endif
    model_reset();
    repeat (3) @(negedge clk);
    n_total++;
    if ({s_tready_o, m_tvalid_o, r_valid_o, r_person_o, r_swid_o, r_lane_o} !== '0)
      $display("FAIL reset_outputs: tready=%0b tvalid=%b rv=%0b rp=%0b swid=%0h lane=%0d want all 0",
               s_tready_o, m_tvalid_o, r_valid_o, r_person_o, r_swid_o, r_lane_o);
    else n_pass++;
`ifdef IP_DISPATCH_OVF_EN
    n_total++;
    if (ovf_o !== '0) $display("FAIL reset_ovf: ovf=%b want 0000", ovf_o);
    else n_pass++;
`endif
    s_aresetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_rr();
    logic [N*SWW-1:0] s;
    s = N*SWW'({$urandom, $urandom});
    res_step('1, N'($urandom), s, 1'b1, 1'b0);
    n_total++;
    if (r_valid_o !== 1'b0) $display("FAIL rr_latency: r_valid=%0b want 0 one cycle after pulse", r_valid_o);
    else n_pass++;
    for (int i = 0; i < N; i++) begin
      res_step('0, '0, '0, 1'b1, 1'b0);
      n_total++;
      if ({r_valid_o, r_lane_o} !== {1'b1, AW'(i)})
        $display("FAIL rr_order step %0d: valid=%0b lane=%0d want 1 %0d", i, r_valid_o, r_lane_o, i);
      else n_pass++;
      n_total++;
      if (got_r() !== exp_r()) $display("FAIL rr_payload step %0d: got %h want %h", i, got_r(), exp_r());
      else n_pass++;
    end
    res_step('0, '0, '0, 1'b1, 1'b0);
    n_total++;
    if (r_valid_o !== 1'b0) $display("FAIL rr_empty: r_valid=%0b want 0", r_valid_o);
    else n_pass++;
  endtask

  task automatic test_ovf();
    logic [SWW-1:0] sw_b;
    sw_b = SWW'(11'h2a5);
    res_step(4'b0001, 4'b0001, (N*SWW)'(11'h011), 1'b0, 1'b0);
    res_step('0, '0, '0, 1'b0, 1'b0);
    res_step(4'b0010, 4'b0010, (N*SWW)'(sw_b) << SWW, 1'b0, 1'b0);
    res_step(4'b0010, 4'b0000, (N*SWW)'(11'h3ff) << SWW, 1'b0, 1'b0);
    n_total++;
    if ({r_valid_o, r_lane_o, r_swid_o} !== {1'b1, AW'(0), SWW'(11'h011)})
      $display("FAIL ovf_held: valid=%0b lane=%0d swid=%0h want 1 0 011", r_valid_o, r_lane_o, r_swid_o);
    else n_pass++;
`ifdef IP_DISPATCH_OVF_EN
    n_total++;
    if (ovf_o !== 4'b0010) $display("FAIL ovf_set: ovf=%b want 0010", ovf_o);
    else n_pass++;
`endif
    res_step('0, '0, '0, 1'b0, 1'b1);
`ifdef IP_DISPATCH_OVF_EN
    n_total++;
    if (ovf_o !== 4'b0000) $display("FAIL ovf_clear: ovf=%b want 0000", ovf_o);
    else n_pass++;
`endif
    res_step('0, '0, '0, 1'b1, 1'b0);
    n_total++;
    if ({r_valid_o, r_lane_o, r_person_o, r_swid_o} !== {1'b1, AW'(1), 1'b1, sw_b})
      $display("FAIL ovf_survivor: valid=%0b lane=%0d person=%0b swid=%0h want 1 1 1 %0h",
               r_valid_o, r_lane_o, r_person_o, r_swid_o, sw_b);
    else n_pass++;
    res_step('0, '0, '0, 1'b1, 1'b0);
    n_total++;
    if (r_valid_o !== 1'b0) $display("FAIL ovf_second_lost: r_valid=%0b want 0", r_valid_o);
    else n_pass++;
  endtask

  task automatic test_random_results();
    for (int c = 0; c < 300 + 12; c++) begin
      logic [N-1:0] v;
      bit drain_phase;
      drain_phase = c >= 300;
      v = drain_phase ? '0 : N'($urandom) & N'($urandom);
      res_step(v, N'($urandom), (N*SWW)'({$urandom, $urandom}),
               drain_phase ? 1'b1 : ($urandom_range(0, 3) != 0),
               drain_phase ? 1'b0 : ($urandom_range(0, 15) == 0));
      n_total++;
      if (got_r() !== exp_r()) $display("FAIL random_result cycle %0d: got %h want %h", c, got_r(), exp_r());
      else n_pass++;
`ifdef IP_DISPATCH_OVF_EN
      n_total++;
      if (ovf_o !== m_ovf) $display("FAIL random_ovf cycle %0d: ovf=%b want %b", c, ovf_o, m_ovf);
      else n_pass++;
`endif
    end
  endtask

  task automatic test_route();
    run_frame(2, 4, 1'b0, 1'b0);
  endtask

  task automatic test_drop();
    run_frame(7, 3, 1'b0, 1'b0);
    run_frame(1, 2, 1'b0, 1'b0);
  endtask

  task automatic test_sticky_sel();
    run_frame(3, 4, 1'b1, 1'b0);
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 8; f++) run_frame($urandom_range(0, 15), $urandom_range(1, 5), 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid_frame();
    res_step(4'b0100, 4'b0100, '0, 1'b0, 1'b0);
    res_step('0, '0, '0, 1'b0, 1'b0);
    n_total++;
    if (r_valid_o !== 1'b1) $display("FAIL midrst_prefill: r_valid=%0b want 1", r_valid_o);
    else n_pass++;
    s_tvalid_i = 1'b1; s_tdest_i = 4'd3; s_tlast_i = 1'b0; s_tdata_i = rand_data();
    @(negedge clk);
    #1;
    n_total++;
    if ({s_tready_o, m_tvalid_o} !== {1'b1, 4'b1000})
      $display("FAIL midrst_routing: tready=%0b tvalid=%b want 1 1000", s_tready_o, m_tvalid_o);
    else n_pass++;
    s_aresetn = 1'b0;
    #1;
    n_total++;
    if ({s_tready_o, m_tvalid_o, r_valid_o} !== '0)
      $display("FAIL midrst_immediate: tready=%0b tvalid=%b rv=%0b want 0", s_tready_o, m_tvalid_o, r_valid_o);
    else n_pass++;
    model_reset();
    repeat (2) @(negedge clk);
    s_tvalid_i = 1'b0;
    s_aresetn = 1'b1;
    #1;
    n_total++;
    if ({s_tready_o, m_tvalid_o, m_tlast_o} !== '0)
      $display("FAIL midrst_idle: tready=%0b tvalid=%b tlast=%b want 0", s_tready_o, m_tvalid_o, m_tlast_o);
    else n_pass++;
    run_frame(1, 3, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_rr();
    test_ovf();
    test_random_results();
    test_route();
    test_drop();
    test_sticky_sel();
    test_random_frames();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ip_dispatch.md
IP_DISPATCH -- requirements
Module: ip_dispatch

Interface
REQ-001 SHALL have parameter IP_AMT, default 4, number of downstream image-processor lanes (1..16).
REQ-002 SHALL have parameter IP_ADDR_W, default $clog2(IP_AMT) (min 1), lane index width.
REQ-003 SHALL have parameter AXIS_TDATA_W, default 256, stream data width.
REQ-004 SHALL have parameters AXIS_TID_W, default 2, and AXIS_TDEST_W, default 4, stream sideband widths.
REQ-005 SHALL have parameter SW_W, default 11, slide-window id width.
REQ-006 SHALL have s_aclk  in  1  the single clock, and s_aresetn  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have s_tid_i/s_tdest_i/s_tdata_i/s_tkeep_i/s_tstrb_i/s_tlast_i/s_tvalid_i  in  and s_tready_o  out  1: AXI-Stream slave; tid, tkeep and tstrb are accepted and ignored.
REQ-008 SHALL have m_tdata_o  out  IP_AMT*AXIS_TDATA_W, m_tlast_o/m_tvalid_o  out  IP_AMT, m_tready_i  in  IP_AMT: per-lane stream, lane k in slice k.
REQ-009 SHALL have res_valid_i  in  IP_AMT, res_person_i  in  IP_AMT, res_swid_i  in  IP_AMT*SW_W: per-lane single-cycle result pulses, no backpressure.
REQ-010 SHALL have r_valid_o  out  1, r_person_o  out  1, r_swid_o  out  SW_W, r_lane_o  out  IP_ADDR_W, r_ready_i  in  1: merged result stream.

Function
REQ-011 Frame FSM SHALL have states IDLE, ROUTE, DROP.
REQ-012 IDLE: s_tready_o=0; on s_tvalid_i, capture sel=s_tdest_i; go to ROUTE if s_tdest_i<IP_AMT, else DROP (1-cycle frame-start latency).
REQ-013 ROUTE: m_tvalid_o[sel]=s_tvalid_i, m_tdata_o/m_tlast_o slice sel driven from input, s_tready_o=m_tready_i[sel]; other lanes m_tvalid_o=0.
REQ-014 DROP: s_tready_o=1, no lane valid, beats discarded.
REQ-015 ROUTE/DROP SHALL return to IDLE on the cycle after a handshake with s_tlast_i=1; sel SHALL not change mid-frame regardless of s_tdest_i.
REQ-016 Each lane SHALL have a one-entry result holding register; res_valid_i[k] loads it when empty, or when being drained the same cycle.
REQ-017 A pulse arriving to a full, non-draining holding register SHALL be dropped and set ovf bit k.
REQ-018 Output arbiter SHALL be round-robin, search starting at lane after last granted (reset pointer: lane 0 highest).
REQ-019 Output register SHALL load the granted entry when empty or when r_valid_o&&r_ready_i; held stable while r_valid_o&&!r_ready_i.
REQ-020 Result path latency SHALL be 2 cycles from res_valid_i pulse to r_valid_o with no contention.

Reset
REQ-021 s_aresetn low SHALL asynchronously force FSM=IDLE, sel=0, all holding registers empty, rr pointer=IP_AMT-1, ovf=0, r_valid_o=0, r_person_o=0, r_swid_o=0, r_lane_o=0.
REQ-022 s_tready_o and all m_tvalid_o SHALL be 0 while reset asserted; a frame interrupted by reset is abandoned, no tlast generated.

Configuration
REQ-023 With IP_DISPATCH_OVF_EN defined, module SHALL add output ovf_o  IP_AMT  (sticky per-lane drop flags) and input ovf_clr_i  1 (clears all flags; set wins over clear in same cycle).
REQ-024 Without IP_DISPATCH_OVF_EN, ports and flags SHALL be absent; drops silent.

Structure
REQ-025 Package ip_dispatch_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-026 Round-robin arbiter SHALL be sub-module ip_rr_arb (parameter N, req in, grant one-hot out, advance in).

Verification
REQ-027 tdest=2, 4-beat frame, all m_tready_i=1 -> beats appear only on lane 2, m_tlast_o[2] on beat 4, FSM IDLE after.
REQ-028 tdest=7 (IP_AMT=4), 3-beat frame -> s_tready_o=1 each beat, no m_tvalid_o asserted, next frame routed normally.
REQ-029 s_tdest_i changed to 1 mid-frame routed to lane 3 -> remaining beats still on lane 3.
REQ-030 res_valid_i=4'b1111 same cycle, r_ready_i=1 -> r_lane_o sequence 0,1,2,3 on consecutive cycles.
REQ-031 r_ready_i=0, lane 1 pulses twice -> first held, second dropped, ovf_o[1]=1 (with OVF_EN); ovf_clr_i clears it.
REQ-032 s_aresetn asserted mid-frame -> s_tready_o, m_tvalid_o, r_valid_o all 0 immediately, FSM IDLE.
